// File: rtl/out_multi.sv
// In-order OUT instruction buffer: captures operands from issue or CDB, then
// streams 1/2/4 little-endian bytes of the head operand to the UART sender at commit.
module out_multi #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_nbytes,
  input  logic              opnd_valid,
  input  logic [TAG_W-1:0]  opnd_tag,
  input  logic [DATA_W-1:0] opnd_data,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              commit_valid,
  output logic              commit_ready,
  output logic              sender_valid,
  input  logic              sender_ready,
  output logic [7:0]        sender_in
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  ent_occ;
  logic [DEPTH-1:0]  ent_valid;
  logic [TAG_W-1:0]  ent_tag  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [1:0]        ent_last [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [1:0]        idx;

  logic              byte_fire;
  logic              commit_fire;
  logic              issue_fire;
  logic              new_cdb_hit;
  logic [1:0]        new_last;
  logic [DATA_W-1:0] head_data;

  // ent_last holds the index of the final byte (0, 1 or 3) rather than the byte count
  always_comb begin
    head_data    = ent_data[head];
    sender_valid = commit_valid && ent_valid[head] && (count != '0);
    byte_fire    = sender_valid && sender_ready;
    commit_ready = byte_fire && (idx == ent_last[head]);
    commit_fire  = commit_valid && commit_ready;
    issue_ready  = (count != CNT_W'(DEPTH)) || commit_ready;
    issue_fire   = issue_valid && issue_ready;
    new_cdb_hit  = cdb_valid && (cdb_tag == opnd_tag);
    new_last     = issue_nbytes[1] ? 2'd3 : {1'b0, issue_nbytes[0]};
    case (idx)
      2'd0:    sender_in = head_data[7:0];
      2'd1:    sender_in = head_data[15:8];
      2'd2:    sender_in = head_data[23:16];
      default: sender_in = head_data[31:24];
    endcase
  end

  // Issue is written after commit so a full-buffer issue can reuse the retiring slot
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      idx       <= '0;
      ent_occ   <= '0;
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_occ[i] && !ent_valid[i] && cdb_valid && (cdb_tag == ent_tag[i])) begin
          ent_valid[i] <= 1'b1;
          ent_data[i]  <= cdb_data;
        end
      end

      if (commit_fire) begin
        ent_occ[head]   <= 1'b0;
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
        idx             <= '0;
      end else if (byte_fire) begin
        idx <= idx + 2'd1;
      end

      if (issue_fire) begin
        ent_occ[tail]  <= 1'b1;
        ent_tag[tail]  <= opnd_tag;
        ent_last[tail] <= new_last;
        if (opnd_valid) begin
          ent_valid[tail] <= 1'b1;
          ent_data[tail]  <= opnd_data;
        end else if (new_cdb_hit) begin
          ent_valid[tail] <= 1'b1;
          ent_data[tail]  <= cdb_data;
        end else begin
          ent_valid[tail] <= 1'b0;
        end
        tail <= tail + PTR_W'(1);
      end

      count <= count + CNT_W'(issue_fire) - CNT_W'(commit_fire);
    end
  end

endmodule

// File: doc/out_multi.md
Name: out_multi

Overview:
- Parametrised successor of the single-byte OUT buffer in the out-of-order core.
- Holds OUT instructions in program order from issue to commit.
- Captures operand data from the GPR read or by snooping the CDB.
- At commit, serialises 1, 2 or 4 little-endian bytes of the operand to the UART sender, and supports a full flush on misprediction recovery.

Parameters:
DEPTH, 4, number of buffer entries; power of two, >=2
TAG_W, 4, ROB tag width (matches ROB_WIDTH)
DATA_W, 32, operand width; multiple of 8, >=32

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  discard all entries (misprediction recovery)
issue_valid  in  1  OUT instruction issued this cycle
issue_ready  out  1  buffer can accept an issue
issue_nbytes  in  2  0:1 byte, 1:2 bytes, 2/3:4 bytes
opnd_valid  in  1  operand data available from GPR read
opnd_tag  in  TAG_W  producer ROB tag when opnd_valid=0
opnd_data  in  DATA_W  operand data when opnd_valid=1
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB ROB tag
cdb_data  in  DATA_W  CDB data
commit_valid  in  1  ROB head is the oldest OUT instruction
commit_ready  out  1  oldest instruction's last byte accepted this cycle
sender_valid  out  1  byte offered to UART sender
sender_ready  in  1  UART sender accepts byte
sender_in  out  8  byte to send

Behaviour:
- Storage:
  - Circular buffer with head pointer, tail pointer and count (0..DEPTH).
  - Each entry holds valid (data ready), tag, data[DATA_W-1:0] and nbytes (1/2/4).
  - A byte index register (0..3) tracks progress of the head entry.
- Reset (synchronous, priority over everything): count=0, head=tail=0, byte index=0, all entry valid=0. Outputs after reset: issue_ready=1, sender_valid=0, commit_ready=0.
- Flush (priority below reset, above all else): same state effect as reset. Any issue, commit or CDB capture in that cycle is dropped. flush together with commit_valid is illegal (bench asserts).
- CDB match means cdb_valid && cdb_tag==entry.tag.
- Wakeup: every occupied entry with valid=0 and a CDB match sets valid=1 and latches cdb_data on the next edge.
- Issue:
  - Fires on issue_valid && issue_ready.
  - Writes the tail entry, increments tail modulo DEPTH and increments count.
  - New entry data source, by priority:
    - opnd_valid=1: valid=1, data=opnd_data.
    - Else CDB match on opnd_tag in the same cycle: valid=1, data=cdb_data.
    - Else valid=0, tag=opnd_tag.
- issue_ready = (count<DEPTH) || commit_ready. A full buffer accepts an issue in the cycle the head completes.
- Commit serialisation:
  - sender_valid = commit_valid && head.valid && count>0.
  - sender_in = head.data[8*idx+7 : 8*idx].
  - On sender_valid && sender_ready with idx < nbytes-1: idx increments.
  - commit_ready = sender_valid && sender_ready && (idx == nbytes-1), combinational.
  - Commit fires on commit_valid && commit_ready: head increments modulo DEPTH, count decrements, idx returns to 0.
  - One byte per cycle at most; latency from head.valid to first byte offered is 0 cycles.
- commit_valid with count=0 is illegal (asserted). While head.valid=0, sender_valid=0 and commit_ready=0; the ROB stalls.
- Simultaneous issue and commit: count unchanged, both pointers advance.
- Simultaneous CDB wakeup of the head and commit: the head is not yet valid that cycle, so no byte is sent; the byte goes out next cycle.
- sender_in is don't-care when sender_valid=0.

Test Plan:
- Reset, then issue nbytes=0 with opnd_valid=1, data=0x000000A5, then commit_valid with sender_ready=1 -> one cycle with sender_valid=1, sender_in=0xA5, commit_ready=1; count returns to 0.
- Issue nbytes=2, data=0x44332211, commit_valid held, sender_ready toggling 1,0,1,1,1 -> bytes 0x11,0x22,0x33,0x44 in order; commit_ready high only with the 0x44 transfer.
- Issue with opnd_valid=0, tag=5; CDB tag=5, data=0x7E two cycles later -> sender_valid stays 0 until the cycle after the CDB; then sends 0x7E. Also the same-cycle issue/CDB match case -> data captured, sent immediately.
- Fill DEPTH=4 entries -> issue_ready=0. Complete the head commit while issue_valid=1 -> issue accepted the same cycle, count stays 4; tail wraps to 0 and order is preserved over 10 further entries.
- Three entries queued, one mid-way through a 4-byte commit (idx=2, commit_valid then deasserted) -> flush -> count=0, idx=0, sender_valid=0, issue_ready=1. A following 1-byte OUT sends its own byte.
- Assert reset mid-serialisation (idx=1) -> next cycle sender_valid=0, commit_ready=0, count=0.
